// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered toward the ALU; result and flags are captured into a held, tagged response.
module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int SEL_W   = 4,
    parameter int MAX_SEL = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_A,
    input  logic [WIDTH-1:0] req0_B,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic             req0_Cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_A,
    input  logic [WIDTH-1:0] req1_B,
    input  logic [SEL_W-1:0] req1_sel,
    input  logic             req1_Cin,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [SEL_W-1:0] alu_sel,
    output logic             alu_Cin,
    input  logic [WIDTH-1:0] alu_Y,
    input  logic             alu_Cout,
    input  logic             alu_Negative,
    input  logic             alu_Zero,
    input  logic             alu_Overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_Y,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [SEL_W-1:0] sel;
        logic             cin;
    } op_t;

    localparam logic [SEL_W-1:0] MAX_SEL_V = SEL_W'(MAX_SEL);

    state_t         state, state_nxt;
    logic [1:0]     req_valid;
    op_t    [1:0]   req_op;
    logic           grant;
    logic           last_grant;
    logic           op_id;
    logic           handshake;
    logic           illegal;

    assign req_valid = {req1_valid, req0_valid};
    assign req_op[0] = {req0_A, req0_B, req0_sel, req0_Cin};
    assign req_op[1] = {req1_A, req1_B, req1_sel, req1_Cin};

    // A tie goes to the port that did not win last; a lone requester always wins.
    always_comb begin
        grant = req_valid[1];
        if (&req_valid)
            grant = ~last_grant;
    end

    assign handshake = (state == IDLE) && req_valid[grant];
    assign illegal   = alu_sel > MAX_SEL_V;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (handshake) state_nxt = EXEC;
            EXEC:    state_nxt = HOLD;
            HOLD:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = (state == IDLE) && req0_valid && !grant;
        req1_ready = (state == IDLE) && req1_valid &&  grant;
        busy       = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_A      <= '0;
            alu_B      <= '0;
            alu_sel    <= '0;
            alu_Cin    <= 1'b0;
            op_id      <= 1'b0;
            last_grant <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_Y      <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (handshake) begin
                {alu_A, alu_B, alu_sel, alu_Cin} <= req_op[grant];
                op_id      <= grant;
                last_grant <= grant;
            end
            // The ALU is combinational, so its outputs are valid the cycle after the operands land.
            if (state == EXEC) begin
                rsp_valid <= 1'b1;
                rsp_id    <= op_id;
                rsp_err   <= illegal;
                rsp_Y     <= illegal ? '0 : alu_Y;
                rsp_flags <= illegal ? 4'b0000
                                     : {alu_Cout, alu_Negative, alu_Zero, alu_Overflow};
            end else if (state == HOLD && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: acts as the ALU, runs directed scenarios, then random traffic
// against a transaction-level model (one outstanding op, alternating tie winner).
module tb_alu_arbiter;

    localparam int WIDTH = 32;
    localparam int SEL_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, req0_Cin;
    logic [WIDTH-1:0] req0_A, req0_B;
    logic [SEL_W-1:0] req0_sel;
    logic             req1_valid, req1_ready, req1_Cin;
    logic [WIDTH-1:0] req1_A, req1_B;
    logic [SEL_W-1:0] req1_sel;
    logic [WIDTH-1:0] alu_A, alu_B, alu_Y;
    logic [SEL_W-1:0] alu_sel;
    logic             alu_Cin, alu_Cout, alu_Negative, alu_Zero, alu_Overflow;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [WIDTH-1:0] rsp_Y;
    logic [3:0]       rsp_flags;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.WIDTH(WIDTH), .SEL_W(SEL_W), .MAX_SEL(5)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B),
        .req0_sel(req0_sel), .req0_Cin(req0_Cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B),
        .req1_sel(req1_sel), .req1_Cin(req1_Cin),
        .alu_A(alu_A), .alu_B(alu_B), .alu_sel(alu_sel), .alu_Cin(alu_Cin),
        .alu_Y(alu_Y), .alu_Cout(alu_Cout), .alu_Negative(alu_Negative),
        .alu_Zero(alu_Zero), .alu_Overflow(alu_Overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_Y(rsp_Y),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // ALU behaviour: {Cout, Negative, Zero, Overflow, Y}. Unsupported opcodes return junk on purpose.
    function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] sel, input logic cin);
        logic [31:0] y;
        logic        c, v;
        c = 1'b0;
        v = 1'b0;
        case (sel)
            4'd0: y = a & b;
            4'd1: y = a | b;
            4'd2: begin
                {c, y} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
                v = (a[31] == b[31]) && (y[31] != a[31]);
            end
            4'd3: begin
                {c, y} = {1'b0, a} + {1'b0, ~b} + {32'd0, cin};
                v = (a[31] != b[31]) && (y[31] != a[31]);
            end
            4'd4: y = a ^ b;
            4'd5: y = ~(a & b);
            default: begin
                y = 32'hDEAD_BEEF;
                c = 1'b1;
                v = 1'b1;
            end
        endcase
        return {c, y[31], (y == 32'd0), v, y};
    endfunction

    assign {alu_Cout, alu_Negative, alu_Zero, alu_Overflow, alu_Y} =
        alu_ref(alu_A, alu_B, alu_sel, alu_Cin);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_A = '0; req0_B = '0; req0_sel = '0; req0_Cin = 1'b0;
        req1_valid = 1'b0; req1_A = '0; req1_B = '0; req1_sel = '0; req1_Cin = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rsp_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rsp_ready = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        checks++;
        if ({alu_A, alu_B, alu_sel, alu_Cin} !== '0) begin
            errors++; $display("FAIL reset_alu_regs: got %h/%h/%h/%b want zeros", alu_A, alu_B, alu_sel, alu_Cin);
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_Y, rsp_flags, rsp_err, busy} !== '0) begin
            errors++; $display("FAIL reset_rsp: got valid=%b id=%b Y=%h flags=%b err=%b busy=%b want zeros",
                               rsp_valid, rsp_id, rsp_Y, rsp_flags, rsp_err, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL reset_first_tie: got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready);
        end
        idle_inputs();
    endtask

    task automatic test_single();
        apply_reset();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_A = 32'h1; req0_B = 32'h1; req0_sel = 4'd0;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL single_ready: got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        #1;
        checks++;
        if ({busy, rsp_valid, alu_A, alu_sel} !== {1'b1, 1'b0, 32'h1, 4'd0}) begin
            errors++; $display("FAIL single_exec: got busy=%b rsp_valid=%b alu_A=%h alu_sel=%h want 1 0 1 0",
                               busy, rsp_valid, alu_A, alu_sel);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_id, rsp_Y, rsp_flags, rsp_err} !== {1'b1, 1'b0, 32'h1, 4'b0000, 1'b0}) begin
            errors++; $display("FAIL single_rsp: got valid=%b id=%b Y=%h flags=%b err=%b want 1 0 1 0000 0",
                               rsp_valid, rsp_id, rsp_Y, rsp_flags, rsp_err);
        end
        tick();
        checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            errors++; $display("FAIL single_release: got valid=%b busy=%b want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_alternate();
        int g = 0;
        int r = 0;
        apply_reset();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_A = 32'h0; req0_B = 32'h0; req0_sel = 4'd1;
        req1_valid = 1'b1; req1_A = 32'h1; req1_B = 32'h0; req1_sel = 4'd4;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req0_ready || req1_ready) begin
                checks++;
                if ({req0_ready, req1_ready} !== ((g % 2 == 0) ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL alt_grant%0d: got r0=%b r1=%b want port %0d", g, req0_ready, req1_ready, g % 2);
                end
                g++;
            end
            if (rsp_valid) begin
                checks++;
                if ((r % 2 == 0) ? ({rsp_id, rsp_Y, rsp_flags} !== {1'b0, 32'h0, 4'b0010})
                                 : ({rsp_id, rsp_Y, rsp_flags} !== {1'b1, 32'h1, 4'b0000})) begin
                    errors++; $display("FAIL alt_rsp%0d: got id=%b Y=%h flags=%b want id=%0d", r, rsp_id, rsp_Y, rsp_flags, r % 2);
                end
                r++;
            end
            tick();
        end
        checks++;
        if (g != 4 || r != 4) begin
            errors++; $display("FAIL alt_count: got grants=%0d responses=%0d want 4 4", g, r);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_backpressure();
        int n = 0;
        apply_reset();
        req0_valid = 1'b1; req0_A = 32'd5; req0_B = 32'd3; req0_sel = 4'd2;
        req1_valid = 1'b1; req1_A = 32'd7; req1_B = 32'd7; req1_sel = 4'd4;
        while (!rsp_valid && n < 6) begin
            tick();
            n++;
        end
        checks++;
        if (!rsp_valid || n != 2) begin
            errors++; $display("FAIL bp_latency: got rsp_valid=%b after %0d cycles want 1 after 2", rsp_valid, n);
        end
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({rsp_valid, rsp_Y, rsp_id, rsp_flags, req0_ready, req1_ready, busy}
                !== {1'b1, 32'd8, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1}) begin
                errors++; $display("FAIL bp_hold%0d: got valid=%b Y=%h id=%b flags=%b r0=%b r1=%b busy=%b want 1 8 0 0000 0 0 1",
                                   i, rsp_valid, rsp_Y, rsp_id, rsp_flags, req0_ready, req1_ready, busy);
            end
            tick();
        end
        rsp_ready = 1'b1;
        idle_inputs();
        tick();
        checks++;
        if ({rsp_valid, busy, rsp_Y} !== {1'b0, 1'b0, 32'd8}) begin
            errors++; $display("FAIL bp_release: got valid=%b busy=%b Y=%h want 0 0 8", rsp_valid, busy, rsp_Y);
        end
    endtask

    task automatic test_illegal();
        apply_reset();
        rsp_ready = 1'b1;
        req1_valid = 1'b1; req1_A = $urandom; req1_B = $urandom; req1_sel = 4'b1001; req1_Cin = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++; $display("FAIL illegal_ready: got r0=%b r1=%b want 0 1", req0_ready, req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        tick();
        checks++;
        if ({rsp_valid, rsp_err, rsp_Y, rsp_flags, rsp_id} !== {1'b1, 1'b1, 32'h0, 4'b0000, 1'b1}) begin
            errors++; $display("FAIL illegal_rsp: got valid=%b err=%b Y=%h flags=%b id=%b want 1 1 0 0000 1",
                               rsp_valid, rsp_err, rsp_Y, rsp_flags, rsp_id);
        end
        tick();
    endtask

    task automatic test_async_reset();
        apply_reset();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_A = 32'h1234; req0_B = 32'h0F0F; req0_sel = 4'd1; req0_Cin = 1'b1;
        tick();
        req0_valid = 1'b0;
        checks++;
        if ({busy, alu_A} !== {1'b1, 32'h1234}) begin
            errors++; $display("FAIL arst_exec: got busy=%b alu_A=%h want 1 1234", busy, alu_A);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({alu_A, alu_B, alu_sel, alu_Cin, rsp_valid, rsp_id, rsp_Y, rsp_flags, rsp_err, busy,
             req0_ready, req1_ready} !== '0) begin
            errors++; $display("FAIL arst_clear: got alu_A=%h alu_B=%h sel=%h cin=%b valid=%b Y=%h flags=%b busy=%b want zeros",
                               alu_A, alu_B, alu_sel, alu_Cin, rsp_valid, rsp_Y, rsp_flags, busy);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            errors++; $display("FAIL arst_no_rsp: got valid=%b busy=%b want 0 0", rsp_valid, busy);
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL arst_first_tie: got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
        end
        idle_inputs();
    endtask

    // Model: at most one op in flight; its response is visible from the second cycle after
    // acceptance until consumed. Ties go to the port that did not win last time.
    task automatic test_random();
        bit               have = 0;
        int               age = 0;
        bit               lg = 1;
        logic [31:0]      ea, eb, ey;
        logic [3:0]       esel, eflags;
        logic             ecin, eid, eerr;
        logic [35:0]      res;
        apply_reset();
        ea = '0; eb = '0; ey = '0; esel = '0; eflags = '0; ecin = 0; eid = 0; eerr = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit want0, want1, gnt;
            req0_valid = ($urandom % 3) != 0;
            req1_valid = ($urandom % 3) != 0;
            req0_A = $urandom; req0_B = $urandom; req0_Cin = $urandom % 2;
            req1_A = $urandom; req1_B = $urandom; req1_Cin = $urandom % 2;
            req0_sel = (($urandom % 10) == 0) ? 4'hF : 4'($urandom % 8);
            req1_sel = (($urandom % 10) == 0) ? 4'hF : 4'($urandom % 8);
            rsp_ready = ($urandom % 4) != 0;
            #1;
            gnt = (req0_valid && req1_valid) ? !lg : req1_valid;
            want0 = !have && req0_valid && !gnt;
            want1 = !have && req1_valid && gnt;
            checks++;
            if ({req0_ready, req1_ready, busy} !== {want0, want1, have}) begin
                errors++; $display("FAIL rnd_ready c%0d: got r0=%b r1=%b busy=%b want %b %b %b",
                                   cyc, req0_ready, req1_ready, busy, want0, want1, have);
            end
            checks++;
            if (rsp_valid !== (have && age >= 1)) begin
                errors++; $display("FAIL rnd_rsp_valid c%0d: got %b want %b", cyc, rsp_valid, have && age >= 1);
            end
            if (have) begin
                checks++;
                if ({alu_A, alu_B, alu_sel, alu_Cin} !== {ea, eb, esel, ecin}) begin
                    errors++; $display("FAIL rnd_alu_ops c%0d: got %h %h %h %b want %h %h %h %b",
                                       cyc, alu_A, alu_B, alu_sel, alu_Cin, ea, eb, esel, ecin);
                end
            end
            if (have && age >= 1) begin
                checks++;
                if ({rsp_Y, rsp_flags, rsp_id, rsp_err} !== {ey, eflags, eid, eerr}) begin
                    errors++; $display("FAIL rnd_rsp c%0d: got Y=%h flags=%b id=%b err=%b want %h %b %b %b",
                                       cyc, rsp_Y, rsp_flags, rsp_id, rsp_err, ey, eflags, eid, eerr);
                end
            end
            if (have) begin
                if (age >= 1 && rsp_ready) have = 0;
                else age++;
            end else if (want0 || want1) begin
                have = 1;
                age = 0;
                lg = gnt;
                eid = gnt;
                ea = gnt ? req1_A : req0_A;
                eb = gnt ? req1_B : req0_B;
                esel = gnt ? req1_sel : req0_sel;
                ecin = gnt ? req1_Cin : req0_Cin;
                res = alu_ref(ea, eb, esel, ecin);
                eerr = esel > 4'd5;
                ey = eerr ? 32'h0 : res[31:0];
                eflags = eerr ? 4'b0000 : res[35:32];
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_illegal();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
